// File: rtl/ccg_bist_driver.sv
// Self-test driver for 12-in/15-out CCG combinational benchmark circuits.
// Applies LFSR vectors to cut_x, compacts cut_f into a MISR, compares to golden.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   start         one-cycle run request (honoured in IDLE or DONE)
//   abort         return to IDLE from any state, signature held
//   pattern_count patterns per run, 0 means 1 (sampled at start)
//   golden        expected signature (sampled at start)
//   cut_x         registered vector to the circuit under test
//   cut_f         circuit response, combinational from cut_x
//   busy          high in APPLY and CAPTURE
//   done          high in DONE
//   signature     MISR contents
//   pass          high in DONE when signature equals latched golden
module ccg_bist_driver #(
    parameter int              IN_W       = 12,
    parameter int              OUT_W      = 15,
    parameter int              SIG_W      = 16,
    parameter logic [IN_W-1:0] SEED       = 12'h001,
    parameter int              SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [12:0]      pattern_count,
    input  logic [SIG_W-1:0] golden,
    output logic [IN_W-1:0]  cut_x,
    input  logic [OUT_W-1:0] cut_f,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature,
    output logic             pass
);

    // x^12+x^6+x^4+x+1 (Galois form) and CRC-CCITT feedback for the MISR
    localparam logic [IN_W-1:0]  LFSR_TAPS   = IN_W'(12'h053);
    localparam logic [SIG_W-1:0] MISR_POLY   = SIG_W'(16'h1021);
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t           state;
    logic [12:0]      n_lat;
    logic [12:0]      pat_cnt;
    logic [3:0]       settle_cnt;
    logic [SIG_W-1:0] golden_lat;

    logic [IN_W-1:0]  lfsr_next;
    logic [SIG_W-1:0] f_ext;
    logic [SIG_W-1:0] sig_next;
    logic [12:0]      n_eff;
    logic             last_pat;

    // cut_x doubles as the LFSR state: the applied vector is always the
    // current LFSR value, so a separate copy would only duplicate flops.
    assign lfsr_next = {cut_x[IN_W-2:0], 1'b0}
                     ^ (cut_x[IN_W-1] ? LFSR_TAPS : '0);

    always_comb begin
        f_ext = '0;
        f_ext[OUT_W-1:0] = cut_f;
    end

    assign sig_next = {signature[SIG_W-2:0], 1'b0}
                    ^ (signature[SIG_W-1] ? MISR_POLY : '0)
                    ^ f_ext;

    assign n_eff    = (pattern_count == 13'd0) ? 13'd1 : pattern_count;
    assign last_pat = (pat_cnt == n_lat - 13'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cut_x      <= '0;
            signature  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            n_lat      <= '0;
            pat_cnt    <= '0;
            settle_cnt <= '0;
            golden_lat <= '0;
        end else if (abort) begin
            // abort wins over start and capture; vector and signature hold
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_APPLY;
                        cut_x      <= SEED;
                        signature  <= '0;
                        pat_cnt    <= '0;
                        settle_cnt <= '0;
                        n_lat      <= n_eff;
                        golden_lat <= golden;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                    end
                end
                S_APPLY: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= S_CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                S_CAPTURE: begin
                    signature  <= sig_next;
                    cut_x      <= lfsr_next;
                    pat_cnt    <= pat_cnt + 13'd1;
                    settle_cnt <= '0;
                    if (last_pat) begin
                        // pass is judged on the final signature being written now
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (sig_next == golden_lat);
                    end else begin
                        state <= S_APPLY;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccg_bist_driver.sv
// Bench for ccg_bist_driver: table vectors, corner sequences, random runs.
// Reference model uses plain polynomial arithmetic on integers.
module tb_ccg_bist_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [12:0] pattern_count = '0;
    logic [15:0] golden = '0;
    logic [11:0] cut_x;
    logic [14:0] cut_f;
    logic        busy;
    logic        done;
    logic [15:0] signature;
    logic        pass;

    logic        loop = 1'b0;
    logic [14:0] f_mask = '0;

    assign cut_f = loop ? ({3'b000, cut_x} ^ f_mask) : f_mask;

    ccg_bist_driver dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .pattern_count (pattern_count),
        .golden        (golden),
        .cut_x         (cut_x),
        .cut_f         (cut_f),
        .busy          (busy),
        .done          (done),
        .signature     (signature),
        .pass          (pass)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    logic [11:0] vec_q[$];
    int          busy_cyc;
    int          gap_cyc;
    bit          timed_out;
    int          mv[8192];

    typedef struct {
        int          n;
        bit          lp;
        logic [14:0] mask;
        logic [15:0] gold;
        logic [15:0] exp_sig;
        bit          exp_pass;
        int          mid;
    } vec_t;

    vec_t tbl[7];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // vector for pattern k: x^k mod (x^12+x^6+x^4+x+1)
    task automatic build_vectors();
        int v;
        v = 1;
        for (int k = 0; k < 8192; k++) begin
            mv[k] = v;
            v = v * 2;
            if (v >= 4096) v = v ^ (4096 + 'h053);
        end
    endtask

    // MISR: s*x + f mod (x^16+x^12+x^5+1)
    function automatic logic [15:0] model_sig(int n, bit lp, int mask);
        int s;
        int f;
        s = 0;
        for (int k = 0; k < n; k++) begin
            f = lp ? (mv[k] ^ mask) : mask;
            s = s * 2;
            if (s >= 65536) s = s ^ (65536 + 'h1021);
            s = s ^ f;
        end
        return 16'(s);
    endfunction

    task automatic run(int n, logic [15:0] g, int mid_start);
        vec_q.delete();
        busy_cyc  = 0;
        gap_cyc   = 0;
        timed_out = 0;
        @(negedge clk);
        pattern_count = 13'(n);
        golden = g;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; ; t++) begin
            if (done) break;
            if (t > 20000) begin
                timed_out = 1;
                break;
            end
            if (busy) begin
                vec_q.push_back(cut_x);
                if (busy_cyc == mid_start) start = 1'b1;
                busy_cyc++;
            end else begin
                gap_cyc++;
            end
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic verify(string tag, int n, logic [15:0] exp_sig, bit exp_pass);
        int ne;
        int bad;
        int zeros;
        ne = (n == 0) ? 1 : n;
        bad = 0;
        zeros = 0;
        for (int i = 0; i < vec_q.size(); i++) begin
            if (int'(vec_q[i]) != mv[i / 3]) bad++;
            if (vec_q[i] == 12'h000) zeros++;
        end
        check({tag, " timeout"}, 32'(timed_out), 32'd0);
        check({tag, " busy cycles"}, busy_cyc, ne * 3);
        check({tag, " gap before done"}, gap_cyc, 0);
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " signature"}, 32'(signature), 32'(exp_sig));
        check({tag, " pass"}, 32'(pass), 32'(exp_pass));
        check({tag, " vector errors"}, bad, 0);
        check({tag, " zero vectors"}, zeros, 0);
    endtask

    initial begin
        logic [15:0] es;
        logic [15:0] g;
        logic [11:0] exp13;
        int          n;
        bit          ok;

        build_vectors();

        tbl[0] = '{4, 1'b0, 15'h0000, 16'h0000, 16'h0000, 1'b1, -1};
        tbl[1] = '{1, 1'b0, 15'h0001, 16'h0001, 16'h0001, 1'b1, -1};
        tbl[2] = '{2, 1'b0, 15'h0001, 16'h0003, 16'h0003, 1'b1, -1};
        tbl[3] = '{2, 1'b0, 15'h0001, 16'h0002, 16'h0003, 1'b0, -1};
        tbl[4] = '{0, 1'b0, 15'h0001, 16'h0001, 16'h0001, 1'b1, -1};
        tbl[5] = '{4, 1'b0, 15'h0000, 16'h0000, 16'h0000, 1'b1, 4};
        tbl[6] = '{13, 1'b1, 15'h0000, 16'h0000, 16'h0000, 1'b1, -1};
        tbl[6].exp_sig = model_sig(13, 1'b1, 0);
        tbl[6].gold    = tbl[6].exp_sig;

        // reset state
        @(negedge clk);
        check("reset cut_x", 32'(cut_x), 32'd0);
        check("reset signature", 32'(signature), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset pass", 32'(pass), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            loop   = tbl[i].lp;
            f_mask = tbl[i].mask;
            run(tbl[i].n, tbl[i].gold, tbl[i].mid);
            verify($sformatf("tbl%0d", i), tbl[i].n,
                   tbl[i].exp_sig, tbl[i].exp_pass);
        end

        // explicit walking sequence for 13 patterns
        for (int k = 0; k < 13; k++) begin
            exp13 = (k < 12) ? 12'(1 << k) : 12'h053;
            check($sformatf("n13 vec%0d", k), 32'(vec_q[k * 3]), 32'(exp13));
        end

        // full period plus one: pattern 4095 wraps to the seed
        loop   = 1'b1;
        f_mask = '0;
        es = model_sig(4096, 1'b1, 0);
        run(4096, es, -1);
        verify("n4096", 4096, es, 1'b1);
        check("n4096 wrap vec", 32'(vec_q[4095 * 3]), 32'h001);

        // abort in the third APPLY
        loop   = 1'b0;
        f_mask = 15'h0001;
        @(negedge clk);
        pattern_count = 13'd5;
        golden = 16'h0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("abort pre busy", 32'(busy), 32'd1);
        check("abort pre sig", 32'(signature), 32'h0003);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort pass", 32'(pass), 32'd0);
        check("abort sig", 32'(signature), 32'h0003);
        repeat (3) @(negedge clk);
        check("abort stays idle", 32'(busy), 32'd0);

        // start together with abort in IDLE stays in IDLE
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start+abort busy", 32'(busy), 32'd0);
        check("start+abort sig", 32'(signature), 32'h0003);

        // asynchronous reset in the middle of CAPTURE
        @(negedge clk);
        pattern_count = 13'd2;
        golden = 16'h0003;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst cut_x", 32'(cut_x), 32'd0);
        check("arst signature", 32'(signature), 32'd0);
        check("arst busy", 32'(busy), 32'd0);
        check("arst done", 32'(done), 32'd0);
        check("arst pass", 32'(pass), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run(2, 16'h0003, -1);
        verify("after arst", 2, 16'h0003, 1'b1);

        // randomized runs against the model
        for (int r = 0; r < 12; r++) begin
            n      = int'($urandom_range(1, 40));
            loop   = 1'($urandom_range(0, 1));
            f_mask = 15'($urandom);
            ok     = 1'($urandom_range(0, 1));
            es = model_sig(n, loop, int'(f_mask));
            g  = ok ? es : (es ^ 16'(1 << $urandom_range(0, 15)));
            run(n, g, -1);
            verify($sformatf("rnd%0d", r), n, es, ok);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
